// File: rtl/instr_fetch_queue.sv
// Instruction source for the DataPath: preloadable instruction memory, fetch
// sequencer and output FIFO streaming words 0..cnt-1 over valid/ready.
module instr_fetch_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W:0]   instr_count,
  input  logic              start,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0]  DEPTH_V   = DEPTH[OCC_W:0];
  localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     pc_q, pc_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   fifo_q [DEPTH];

  logic                issue;
  logic                mem_we;
  logic                push;
  logic                pop;
  logic [OCC_W:0]      pending;
  logic [ADDR_W:0]     start_cnt;

  // Sequencer: occupancy check uses pre-pop FIFO count plus the read in flight.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    pending   = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    start_cnt = instr_count[ADDR_W] ? MEM_WORDS : instr_count;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = start_cnt;
          pc_d    = '0;
          state_d = (start_cnt == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if ((pc_q < cnt_q) && (pending < DEPTH_V)) begin
          issue = 1'b1;
          pc_d  = pc_q + 1'b1;
          if (pc_d == cnt_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (occ_q == '0)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d = issue;
  end

  always_comb begin
    mem_we   = load_en && ((state_q == S_IDLE) || (state_q == S_DONE));
    push     = inflight_q;
    pop      = instr_valid && instr_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Storage arrays carry no reset so they map onto RAM; program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
    if (issue) begin
      rd_data_q <= mem_q[pc_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= rd_data_q;
    end
  end

  always_comb begin
    instr_valid = (occ_q != '0);
    instr_out   = fifo_q[rd_ptr_q];
    busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: cycle table for a basic run, then
// stall, reset, load-while-busy, zero-count, full-memory and clamp sequences.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [6:0]  instr_count = '0;
  logic        start = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.DATA_W(32), .ADDR_W(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instr_count(instr_count), .start(start),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic [6:0]  cnt;
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_out;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic le, input logic [5:0] la,
                     input logic [31:0] ld, input logic [6:0] c, input logic s,
                     input logic rdy, input logic ev, input logic [31:0] eo,
                     input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.load_en = le; v.load_addr = la; v.load_data = ld;
    v.cnt = c; v.start = s; v.ready = rdy; v.exp_valid = ev;
    v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [6:0] c);
    instr_count = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Consume a stream, expecting base+i in order, then done with nothing left.
  task automatic drain_stream(input int n, input bit rnd, input logic [31:0] base,
                              input string name);
    int got = 0;
    bit hold = 0;
    logic [31:0] held = '0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (hold) begin
        chk({name, "_hold_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({name, "_hold_data"}, instr_out, held);
      end
      instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (instr_valid && instr_ready) begin
        chk({name, "_data"}, instr_out, base + 32'(got));
        got++;
      end
      hold = instr_valid && !instr_ready;
      held = instr_out;
      step();
    end
    chk({name, "_count"}, 32'(got), 32'(n));
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_valid_after"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    // Basic run: start at the row-5 edge (k); A0 visible after k+2, done at k+7.
    add(1, 0, 0, 0,        0, 0, 1, 0, 0,        0, 0);
    add(0, 1, 0, 32'hA0,   0, 0, 1, 0, 0,        0, 0);
    add(0, 1, 1, 32'hA1,   0, 0, 1, 0, 0,        0, 0);
    add(0, 1, 2, 32'hA2,   0, 0, 1, 0, 0,        0, 0);
    add(0, 1, 3, 32'hA3,   0, 0, 1, 0, 0,        0, 0);
    add(0, 0, 0, 0,        4, 1, 1, 0, 0,        1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 0, 0,        1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 1, 32'hA0,   1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 1, 32'hA1,   1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 1, 32'hA2,   1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 1, 32'hA3,   1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 0, 0,        1, 0);
    add(0, 0, 0, 0,        4, 0, 1, 0, 0,        0, 1);
    add(0, 0, 0, 0,        4, 0, 1, 0, 0,        0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; load_en = vecs[i].load_en; load_addr = vecs[i].load_addr;
      load_data = vecs[i].load_data; instr_count = vecs[i].cnt;
      start = vecs[i].start; instr_ready = vecs[i].ready;
      step();
      chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
      if (vecs[i].exp_valid) chk($sformatf("tbl%0d_out", i), instr_out, vecs[i].exp_out);
    end
    rst = 1'b0; load_en = 1'b0; start = 1'b0;

    // Stall: no ready for 10 cycles, FIFO fills, head holds A0.
    instr_ready = 1'b0;
    start_run(7'd4);
    for (int c = 0; c < 10; c++) step();
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_head", instr_out, 32'hA0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_done", {31'd0, done}, 32'd0);
    drain_stream(4, 0, 32'hA0, "stall");

    // Reset mid-run after two transfers, then replay from mem[0].
    instr_ready = 1'b1;
    start_run(7'd4);
    begin
      int got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
        if (instr_valid) got++;
        step();
      end
      chk("rstmid_pre_transfers", 32'(got), 32'd2);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_valid", {31'd0, instr_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    step();
    chk("rstmid_valid_later", {31'd0, instr_valid}, 32'd0);
    start_run(7'd4);
    drain_stream(4, 0, 32'hA0, "replay");

    // Load and a second start while busy must both be ignored.
    start_run(7'd4);
    load_en = 1'b1; load_addr = 6'd2; load_data = 32'hFF;
    start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("busyload_busy", {31'd0, busy}, 32'd1);
    drain_stream(4, 0, 32'hA0, "busyload");

    // Zero count: done after one edge, busy and valid stay low.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("zero_pre_done", {31'd0, done}, 32'd0);
    start_run(7'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_valid", {31'd0, instr_valid}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("zero_busy_later", {31'd0, busy}, 32'd0);
      chk("zero_valid_later", {31'd0, instr_valid}, 32'd0);
    end

    // Full memory, random ready; then an over-range count clamps to 64.
    for (int i = 0; i < 64; i++) begin
      load_en = 1'b1; load_addr = 6'(i); load_data = 32'(i);
      step();
    end
    load_en = 1'b0;
    instr_ready = 1'b0;
    start_run(7'd64);
    drain_stream(64, 1, 32'd0, "full64");
    start_run(7'd100);
    drain_stream(64, 0, 32'd0, "clamp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
